// File: rtl/mips_pkg.sv
// Shared MIPS multicycle datapath definitions: widths, special register numbers
// and the write-register-select encoding used by the destination selector.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int SP_RESET = 227;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      WR_SEL_RD = 2'b00,
      WR_SEL_RT = 2'b01,
      WR_SEL_RA = 2'b10,
      WR_SEL_SP = 2'b11
   } wr_sel_e;

   // Destination register chosen by the write-register selector.
   function automatic logic [4:0] wr_sel_addr(input wr_sel_e sel,
                                              input logic [4:0] rd,
                                              input logic [4:0] rt);
      case (sel)
         WR_SEL_RD: wr_sel_addr = rd;
         WR_SEL_RT: wr_sel_addr = rt;
         WR_SEL_RA: wr_sel_addr = REG_RA;
         default:   wr_sel_addr = REG_SP;
      endcase
   endfunction

endpackage

// File: rtl/ld_reg.sv
// Generic register with load enable and asynchronous active-high clear.
// Used for the A/B operand latches; also suits PC, IR and MDR.
module ld_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/reg_bank_ab.sv
// 32-entry MIPS register file with two combinational read ports and the
// registered A/B operand latches that feed the ALU source muxes.
module reg_bank_ab #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int SP_RESET = mips_pkg::SP_RESET
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic              LoadAB,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] A_out,
   output logic [DATA_W-1:0] B_out
);

   import mips_pkg::*;

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];

   // $0 is cleared by reset and never written, so it stays hard zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         regs[ADDR_W'(REG_SP)] <= DATA_W'(SP_RESET);
      end else if (RegWrite && (WriteReg != ADDR_W'(REG_ZERO))) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // No write bypass: a same-cycle write is visible only after the edge.
   assign ReadData1 = (ReadReg1 == ADDR_W'(REG_ZERO)) ? '0 : regs[ReadReg1];
   assign ReadData2 = (ReadReg2 == ADDR_W'(REG_ZERO)) ? '0 : regs[ReadReg2];

   ld_reg #(.DATA_W(DATA_W)) u_a_reg (
      .clk   (clk),
      .reset (reset),
      .load  (LoadAB),
      .d     (ReadData1),
      .q     (A_out)
   );

   ld_reg #(.DATA_W(DATA_W)) u_b_reg (
      .clk   (clk),
      .reset (reset),
      .load  (LoadAB),
      .d     (ReadData2),
      .q     (B_out)
   );

endmodule

// File: tb/tb_reg_bank_ab.sv
// Directed scoreboard bench for reg_bank_ab: expectations are queued as stimulus
// is driven and compared against the DUT outputs once they are due.
module tb_reg_bank_ab;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic        LoadAB;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] A_out;
   logic [31:0] B_out;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   typedef struct {
      string       tag;
      int          port;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];

   reg_bank_ab dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .LoadAB    (LoadAB),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .A_out     (A_out),
      .B_out     (B_out)
   );

   always #5 clk = ~clk;

   // Port codes: 1 ReadData1, 2 ReadData2, 3 A_out, 4 B_out.
   function automatic logic [31:0] observe(input int port);
      case (port)
         1:       observe = ReadData1;
         2:       observe = ReadData2;
         3:       observe = A_out;
         default: observe = B_out;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int port, input logic [31:0] exp);
      item_t it;
      it.tag  = tag;
      it.port = port;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   task automatic drain();
      item_t       it;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         it  = sb.pop_front();
         obs = observe(it.port);
         total = total + 1;
         assert (obs === it.exp) passed = passed + 1;
         else begin
            failed = failed + 1;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      RegWrite  = 1'b0;
      WriteReg  = 5'd0;
      WriteData = 32'd0;
      ReadReg1  = 5'd0;
      ReadReg2  = 5'd0;
      LoadAB    = 1'b0;

      // Junk write and load before any reset, then reset mid-cycle.
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'd111; LoadAB = 1'b1;
      ReadReg1 = 5'd8; ReadReg2 = 5'd29;
      @(posedge clk);
      #2;
      reset = 1'b1;
      expect_val("rst_rd1_r8", 1, 32'd0);
      expect_val("rst_rd2_sp", 2, 32'd227);
      expect_val("rst_a", 3, 32'd0);
      expect_val("rst_b", 4, 32'd0);
      drain();
      ReadReg1 = 5'd31; ReadReg2 = 5'd0;
      expect_val("rst_rd1_r31", 1, 32'd0);
      expect_val("rst_rd2_r0", 2, 32'd0);
      drain();
      RegWrite = 1'b0; LoadAB = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Write and read back reg 8.
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd8;
      expect_val("pre_write_old", 1, 32'd0);
      drain();
      tick();
      expect_val("write_r8", 1, 32'hDEADBEEF);
      drain();
      RegWrite = 1'b0; WriteData = 32'h12345678;
      tick();
      expect_val("no_we_hold", 1, 32'hDEADBEEF);
      drain();

      // $0 protection.
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0;
      tick();
      expect_val("r0_zero", 1, 32'd0);
      drain();

      // Same-cycle write + load collision on reg 9.
      WriteReg = 5'd9; WriteData = 32'd5;
      tick();
      WriteData = 32'd7; LoadAB = 1'b1; ReadReg1 = 5'd9; ReadReg2 = 5'd8;
      expect_val("coll_pre", 1, 32'd5);
      drain();
      tick();
      expect_val("coll_a_old", 3, 32'd5);
      expect_val("coll_b", 4, 32'hDEADBEEF);
      expect_val("coll_reg_new", 1, 32'd7);
      drain();
      RegWrite = 1'b0;
      tick();
      expect_val("coll_a_new", 3, 32'd7);
      drain();

      // Hold: LoadAB low while read addresses move.
      LoadAB = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ReadReg1 = 5'(29 - i * 10);
         ReadReg2 = 5'(i + 1);
         tick();
         expect_val($sformatf("hold_a_%0d", i), 3, 32'd7);
         expect_val($sformatf("hold_b_%0d", i), 4, 32'hDEADBEEF);
         drain();
      end
      ReadReg1 = 5'd8; ReadReg2 = 5'd8;
      expect_val("same_addr_p1", 1, 32'hDEADBEEF);
      expect_val("same_addr_p2", 2, 32'hDEADBEEF);
      drain();

      // jal / stack path writes through the selector encoding.
      RegWrite = 1'b1;
      WriteReg = wr_sel_addr(WR_SEL_RA, 5'd3, 5'd4); WriteData = 32'h00400010;
      tick();
      WriteReg = wr_sel_addr(WR_SEL_SP, 5'd3, 5'd4); WriteData = 32'd223;
      tick();
      RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd29;
      expect_val("ra_write", 1, 32'h00400010);
      expect_val("sp_write", 2, 32'd223);
      drain();
      LoadAB = 1'b1;
      tick();
      LoadAB = 1'b0;
      expect_val("ab_load_ra", 3, 32'h00400010);
      expect_val("ab_load_sp", 4, 32'd223);
      drain();

      // Reset mid-cycle discards a pending write and restores defaults.
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd10; WriteData = 32'd55;
      #2;
      reset = 1'b1;
      expect_val("rst2_ra", 1, 32'd0);
      expect_val("rst2_sp", 2, 32'd227);
      expect_val("rst2_a", 3, 32'd0);
      expect_val("rst2_b", 4, 32'd0);
      drain();
      tick();
      @(negedge clk);
      reset = 1'b0; RegWrite = 1'b0;
      ReadReg1 = 5'd10; ReadReg2 = 5'd8;
      expect_val("rst_discard_r10", 1, 32'd0);
      expect_val("rst_clear_r8", 2, 32'd0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reg_bank_ab.md
Name: reg_bank_ab

Overview:
- 32 x 32-bit MIPS general-purpose register file for the multicycle datapath, directly downstream of the write-register-address selector.
- Takes the selected 5-bit destination (rd, rt, $31 or $29) plus write data, and performs the architectural write.
- Provides two combinational read ports, plus the registered A/B operand latches that feed the ALU source muxes in the following cycle.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- SP_RESET, 227, reset value of $29 (stack pointer)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- RegWrite  in  1  write enable for the register file
- WriteReg  in  ADDR_W  destination register address (from the write-register selector)
- WriteData  in  DATA_W  data to write
- ReadReg1  in  ADDR_W  read port 1 address (instruction rs field)
- ReadReg2  in  ADDR_W  read port 2 address (instruction rt field)
- LoadAB  in  1  load enable for the A/B operand latches
- ReadData1  out  DATA_W  combinational contents of ReadReg1
- ReadData2  out  DATA_W  combinational contents of ReadReg2
- A_out  out  DATA_W  registered operand A
- B_out  out  DATA_W  registered operand B

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high, named reset. It acts immediately, independent of clk.
- Values while reset is asserted:
  - All registers are 0, except $29 = SP_RESET.
  - A_out = 0 and B_out = 0.
  - ReadData1/2 reflect those reset contents.
- Reset asserted mid-operation discards any write in that cycle.
- First write possible: the first rising edge after reset deasserts.
- Write: on a rising clk edge with RegWrite=1 and WriteReg != 0, reg[WriteReg] <= WriteData.
  - Writes to $0 are ignored; $0 always reads 0.
  - Writes to $29 and $31 are ordinary writes (used by the jal and stack paths).
- Read: ReadData1/2 = reg[ReadReg1/2], purely combinational, zero latency. There is no write-to-read bypass.
  - Same-cycle write and read of the same address: ReadData shows the old value until the edge and the new value after it.
- A/B latches: on a rising edge with LoadAB=1, A_out <= ReadData1 and B_out <= ReadData2, sampled pre-edge. Otherwise they hold.
  - If RegWrite and LoadAB are asserted in the same cycle to the same address, A/B capture the OLD value and the register takes the new one.
- ReadReg1 = ReadReg2 is legal; both ports return the same value.
- X/undefined addresses are not handled specially; the bench drives only known values.
- No multi-cycle state machine. Sequential state is the 31 writable registers plus A and B.
- Latencies:
  - write to readback: 1 edge.
  - read to A/B: 1 edge.
  - write to A/B reflecting it: 2 edges.

Decomposition:
- Shared package (mips_pkg), holding:
  - constants DATA_W=32 and ADDR_W=5
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31
  - SP_RESET=227
  - the WriteReg-select encoding (00 rd, 01 rt, 10 $31, 11 $29), so the selector and the bench agree
- One natural sub-module: ld_reg, a DATA_W-bit register with load enable and async active-high reset to 0. It is instantiated twice, for A and B; the same cell is reusable for the PC, IR and MDR.

Test Plan:
- Reset: assert reset mid-cycle without waiting for clk -> immediately all ReadData = 0 except ReadReg=29 -> 227; A_out = B_out = 0.
- Write/read: RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one edge; ReadReg1=8 -> ReadData1 = 32'hDEADBEEF. RegWrite=0 with new data -> value unchanged.
- $0 protection: RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF -> ReadData1 with ReadReg1=0 stays 0 after the edge.
- Same-cycle collision: reg9 = 5. Then RegWrite=1, WriteReg=9, WriteData=7, LoadAB=1, ReadReg1=9, one edge -> A_out = 5 and reg9 = 7. Next LoadAB edge -> A_out = 7.
- jal/stack path: write $31 = 32'h00400010 and $29 = 223 -> readback exact. Then assert reset -> $31 = 0 and $29 = 227.
- Hold: LoadAB=0 for 3 edges while reads change -> A_out/B_out unchanged. Two ports on the same address (ReadReg1 = ReadReg2 = 8) -> both read 32'hDEADBEEF.
